// File: rtl/sdram_port_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : sdram_port_arbiter                                             |
// | Brief   : Round-robin arbiter sharing one Wishbone slave port of the     |
// |           SDRAM controller among M_NUM masters. Each tenure is capped    |
// |           at MAX_HOLD acknowledged beats while others are waiting.       |
// | Option  : define SDRAM_ARB_WATCHDOG_EN to abort transfers that see no    |
// |           slave ack for WDOG_CYCLES cycles (m_err_o pulse to owner).     |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module sdram_port_arbiter #(
  parameter int M_NUM       = 4,
  parameter int ADDR_WIDTH  = 25,
  parameter int DATA_WIDTH  = 32,
  parameter int SEL_WIDTH   = 4,
  parameter int MAX_HOLD    = 16,
  parameter int WDOG_CYCLES = 1024
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [M_NUM-1:0]            m_cyc_i,
  input  logic [M_NUM-1:0]            m_stb_i,
  input  logic [M_NUM-1:0]            m_we_i,
  input  logic [M_NUM*ADDR_WIDTH-1:0] m_adr_i,
  input  logic [M_NUM*DATA_WIDTH-1:0] m_dat_i,
  input  logic [M_NUM*SEL_WIDTH-1:0]  m_sel_i,
  output logic [DATA_WIDTH-1:0]       m_dat_o,
  output logic [M_NUM-1:0]            m_ack_o,
  output logic [M_NUM-1:0]            m_err_o,
  output logic [M_NUM-1:0]            grant_o,
  output logic                        s_cyc_o,
  output logic                        s_stb_o,
  output logic                        s_we_o,
  output logic [ADDR_WIDTH-1:0]       s_adr_o,
  output logic [DATA_WIDTH-1:0]       s_dat_o,
  output logic [SEL_WIDTH-1:0]        s_sel_o,
  input  logic [DATA_WIDTH-1:0]       s_dat_i,
  input  logic                        s_ack_i
);

  localparam int         c_idx_w    = $clog2(M_NUM);
  localparam logic [7:0] c_max_hold = 8'(MAX_HOLD);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    OWN  = 1'b1
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [M_NUM-1:0]     r_grant;
  logic [M_NUM-1:0]     w_grant_nxt;
  logic [c_idx_w-1:0]   r_gidx;
  logic [c_idx_w-1:0]   w_gidx_nxt;
  logic [c_idx_w-1:0]   r_rr_ptr;
  logic [c_idx_w-1:0]   w_rr_ptr_nxt;
  logic [7:0]           r_beat_cnt;
  logic [7:0]           w_beat_nxt;

  logic                 w_pick_found;
  logic [c_idx_w-1:0]   w_pick_idx;
  logic [c_idx_w-1:0]   w_cand;
  logic [c_idx_w-1:0]   w_after_owner;
  logic                 w_others;
  logic                 w_hold_done;
  logic                 w_preempt;
  logic                 w_abort;

  logic [ADDR_WIDTH-1:0] w_adr  [M_NUM];
  logic [DATA_WIDTH-1:0] w_wdat [M_NUM];
  logic [SEL_WIDTH-1:0]  w_sel  [M_NUM];

  // Split the flattened master buses into per-master words for muxing.
  for (genvar gi = 0; gi < M_NUM; gi++) begin : g_unpack
    assign w_adr[gi]  = m_adr_i[gi*ADDR_WIDTH +: ADDR_WIDTH];
    assign w_wdat[gi] = m_dat_i[gi*DATA_WIDTH +: DATA_WIDTH];
    assign w_sel[gi]  = m_sel_i[gi*SEL_WIDTH +: SEL_WIDTH];
  end

  // Next round-robin start point: the master just after the current owner.
  assign w_after_owner = (r_gidx == c_idx_w'(M_NUM - 1)) ? '0 : r_gidx + c_idx_w'(1);

  // Anyone other than the owner asking for the bus.
  assign w_others = |(m_cyc_i & ~r_grant);

  // The beat being acked now uses up the tenure budget. Compared with >= so a
  // tenure that ran past the budget alone still yields once someone arrives.
  assign w_hold_done = ({1'b0, r_beat_cnt} + 9'd1) >= {1'b0, c_max_hold};
  assign w_preempt   = s_ack_i && w_hold_done && w_others;

`ifdef SDRAM_ARB_WATCHDOG_EN
  localparam logic [15:0] c_wdog_limit = 16'(WDOG_CYCLES);
  logic [15:0] r_wdog;

  assign w_abort = (r_state == OWN) && (r_wdog == c_wdog_limit);

  // Count strobe cycles that go unanswered; any ack or idle strobe clears it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wdog <= '0;
    end else if (s_stb_o && !s_ack_i) begin
      r_wdog <= r_wdog + 16'd1;
    end else begin
      r_wdog <= '0;
    end
  end
`else
  assign w_abort = 1'b0;
`endif

  // Find the first requesting master at or after the round-robin pointer.
  always_comb begin
    w_pick_found = 1'b0;
    w_pick_idx   = '0;
    w_cand       = '0;
    for (int k = 0; k < M_NUM; k++) begin
      w_cand = c_idx_w'((int'(r_rr_ptr) + k) % M_NUM);
      if (!w_pick_found && m_cyc_i[w_cand]) begin
        w_pick_found = 1'b1;
        w_pick_idx   = w_cand;
      end
    end
  end

  // Next-state logic plus the bus multiplexer onto the slave and back.
  always_comb begin
    w_state_nxt  = r_state;
    w_grant_nxt  = r_grant;
    w_gidx_nxt   = r_gidx;
    w_rr_ptr_nxt = r_rr_ptr;
    w_beat_nxt   = r_beat_cnt;
    s_cyc_o      = 1'b0;
    s_stb_o      = 1'b0;
    s_we_o       = 1'b0;
    s_adr_o      = '0;
    s_dat_o      = '0;
    s_sel_o      = '0;
    m_dat_o      = '0;
    m_ack_o      = '0;
    m_err_o      = '0;

    case (r_state)
      IDLE: begin
        if (w_pick_found) begin
          w_state_nxt             = OWN;
          w_grant_nxt             = '0;
          w_grant_nxt[w_pick_idx] = 1'b1;
          w_gidx_nxt              = w_pick_idx;
          w_beat_nxt              = '0;
        end
      end

      OWN: begin
        if (w_abort) begin
          // Hung slave: report to the owner, drop the bus, move on.
          m_err_o[r_gidx] = 1'b1;
          w_state_nxt     = IDLE;
          w_grant_nxt     = '0;
          w_rr_ptr_nxt    = w_after_owner;
        end else begin
          s_cyc_o         = m_cyc_i[r_gidx];
          s_stb_o         = m_stb_i[r_gidx];
          s_we_o          = m_we_i[r_gidx];
          s_adr_o         = w_adr[r_gidx];
          s_dat_o         = w_wdat[r_gidx];
          s_sel_o         = w_sel[r_gidx];
          m_ack_o[r_gidx] = s_ack_i;
          m_dat_o         = s_dat_i;

          if (s_ack_i && (r_beat_cnt != c_max_hold)) begin
            w_beat_nxt = r_beat_cnt + 8'd1;
          end

          if (!m_cyc_i[r_gidx] || w_preempt) begin
            w_state_nxt  = IDLE;
            w_grant_nxt  = '0;
            w_rr_ptr_nxt = w_after_owner;
          end
        end
      end

      default: begin
        w_state_nxt = IDLE;
        w_grant_nxt = '0;
      end
    endcase
  end

  // State and arbitration registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= IDLE;
      r_grant    <= '0;
      r_gidx     <= '0;
      r_rr_ptr   <= '0;
      r_beat_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_grant    <= w_grant_nxt;
      r_gidx     <= w_gidx_nxt;
      r_rr_ptr   <= w_rr_ptr_nxt;
      r_beat_cnt <= w_beat_nxt;
    end
  end

  assign grant_o = r_grant;

endmodule
`default_nettype wire

// File: tb/tb_sdram_port_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : tb_sdram_port_arbiter                                          |
// | Brief   : Directed self-checking bench for sdram_port_arbiter using      |
// |           simple Wishbone master and one-wait-state slave models.        |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module tb_sdram_port_arbiter;

  localparam int M_NUM       = 4;
  localparam int ADDR_WIDTH  = 25;
  localparam int DATA_WIDTH  = 32;
  localparam int SEL_WIDTH   = 4;
  localparam int MAX_HOLD    = 4;
  localparam int WDOG_CYCLES = 8;
  localparam int MAX_TEN     = 16;

  logic                        clk = 1'b0;
  logic                        reset;
  logic [M_NUM-1:0]            m_cyc_i, m_stb_i, m_we_i;
  logic [M_NUM*ADDR_WIDTH-1:0] m_adr_i;
  logic [M_NUM*DATA_WIDTH-1:0] m_dat_i;
  logic [M_NUM*SEL_WIDTH-1:0]  m_sel_i;
  logic [DATA_WIDTH-1:0]       m_dat_o;
  logic [M_NUM-1:0]            m_ack_o, m_err_o, grant_o;
  logic                        s_cyc_o, s_stb_o, s_we_o;
  logic [ADDR_WIDTH-1:0]       s_adr_o;
  logic [DATA_WIDTH-1:0]       s_dat_o;
  logic [SEL_WIDTH-1:0]        s_sel_o;
  logic [DATA_WIDTH-1:0]       s_dat_i;
  logic                        s_ack_i;

  sdram_port_arbiter #(
    .M_NUM(M_NUM), .ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH),
    .SEL_WIDTH(SEL_WIDTH), .MAX_HOLD(MAX_HOLD), .WDOG_CYCLES(WDOG_CYCLES)
  ) u_dut (
    .clk(clk), .reset(reset),
    .m_cyc_i(m_cyc_i), .m_stb_i(m_stb_i), .m_we_i(m_we_i),
    .m_adr_i(m_adr_i), .m_dat_i(m_dat_i), .m_sel_i(m_sel_i),
    .m_dat_o(m_dat_o), .m_ack_o(m_ack_o), .m_err_o(m_err_o), .grant_o(grant_o),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o),
    .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_sel_o(s_sel_o),
    .s_dat_i(s_dat_i), .s_ack_i(s_ack_i)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Master / slave model state and observation log.
  int                    mst_rem [M_NUM];
  logic [ADDR_WIDTH-1:0] mst_adr [M_NUM];
  int                    ack_cnt [M_NUM];
  logic                  slv_en;
  logic                  slv_seen;
  int                    cyc_no;
  int                    n_ten;
  int                    ten_idx   [MAX_TEN];
  int                    ten_gap   [MAX_TEN];
  int                    ten_acks  [MAX_TEN];
  int                    ten_start [MAX_TEN];
  int                    idle_run;
  logic [M_NUM-1:0]      prev_grant;
  logic [M_NUM-1:0]      last_grant;
  int                    err_cnt;
  int                    err_cyc;
  logic                  err_stb;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int onehot_idx(input logic [M_NUM-1:0] v);
    int r = -1;
    for (int i = 0; i < M_NUM; i++) if (v[i]) r = i;
    return r;
  endfunction

  task automatic clear_log();
    n_ten      = 0;
    idle_run   = 0;
    prev_grant = '0;
    for (int i = 0; i < M_NUM; i++) ack_cnt[i] = 0;
    for (int k = 0; k < MAX_TEN; k++) begin
      ten_idx[k] = -1; ten_gap[k] = -1; ten_acks[k] = -1; ten_start[k] = -1;
    end
  endtask

  task automatic clear_bus();
    for (int i = 0; i < M_NUM; i++) begin
      mst_rem[i] = 0;
      mst_adr[i] = '0;
    end
    m_cyc_i = '0; m_stb_i = '0; m_we_i = '0;
    m_adr_i = '0; m_dat_i = '0; m_sel_i = '0;
    s_dat_i = '0; s_ack_i = 1'b0; slv_seen = 1'b0;
  endtask

  // One clock: drive masters at negedge, let the slave answer, then observe.
  task automatic cycle();
    @(negedge clk);
    for (int i = 0; i < M_NUM; i++) begin
      m_cyc_i[i] = (mst_rem[i] > 0);
      m_stb_i[i] = (mst_rem[i] > 0);
      m_we_i[i]  = 1'b1;
      m_adr_i[i*ADDR_WIDTH +: ADDR_WIDTH] = mst_adr[i];
      m_dat_i[i*DATA_WIDTH +: DATA_WIDTH] = 32'hA000_0000 | 32'(mst_adr[i]);
      m_sel_i[i*SEL_WIDTH +: SEL_WIDTH]   = 4'hF;
    end
    #1;
    s_dat_i = 32'hD000_0000 | 32'(cyc_no);
    if (slv_en && s_stb_o && slv_seen) begin
      s_ack_i  = 1'b1;
      slv_seen = 1'b0;
    end else begin
      s_ack_i  = 1'b0;
      slv_seen = s_stb_o;
    end
    #1;
    cyc_no++;
    last_grant = grant_o;
    if (grant_o != '0 && grant_o != prev_grant && n_ten < MAX_TEN) begin
      ten_idx[n_ten]   = onehot_idx(grant_o);
      ten_gap[n_ten]   = idle_run;
      ten_acks[n_ten]  = 0;
      ten_start[n_ten] = cyc_no;
      n_ten++;
    end
    idle_run   = (grant_o == '0) ? idle_run + 1 : 0;
    prev_grant = grant_o;
    for (int i = 0; i < M_NUM; i++) begin
      if (m_ack_o[i]) begin
        check("ack_adr", 64'(s_adr_o), 64'(mst_adr[i]));
        check("ack_rdat", 64'(m_dat_o), 64'(s_dat_i));
        check("ack_wdat", 64'(s_dat_o), 64'(32'hA000_0000 | 32'(mst_adr[i])));
        ack_cnt[i]++;
        mst_rem[i]--;
        mst_adr[i]++;
        if (n_ten > 0) ten_acks[n_ten-1]++;
      end
      if (m_err_o[i]) begin
        err_cnt++;
        err_cyc    = cyc_no;
        err_stb    = s_stb_o;
        mst_rem[i] = 0;
      end
    end
  endtask

  function automatic logic busy();
    logic b = 1'b0;
    for (int i = 0; i < M_NUM; i++) if (mst_rem[i] > 0) b = 1'b1;
    return b;
  endfunction

  task automatic run_idle(input string tag, input int bound);
    int n = 0;
    do begin
      cycle();
      n++;
    end while ((busy() || last_grant != '0) && n < bound);
    check(tag, 64'(n < bound), 64'd1);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    reset = 1'b0;
    clear_bus();
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset   = 1'b0;
    slv_en  = 1'b1;
    cyc_no  = 0;
    err_cnt = 0;
    err_cyc = -1;
    err_stb = 1'b0;
    last_grant = '0;
    clear_bus();
    clear_log();
    repeat (2) @(negedge clk);
    #2;
    check("rst_grant", 64'(grant_o), 64'd0);
    check("rst_scyc",  64'(s_cyc_o), 64'd0);
    check("rst_sstb",  64'(s_stb_o), 64'd0);
    check("rst_sadr",  64'(s_adr_o), 64'd0);
    check("rst_ack",   64'(m_ack_o), 64'd0);
    check("rst_err",   64'(m_err_o), 64'd0);
    @(negedge clk);
    reset = 1'b1;

    // Single master 0: four writes at 0x10..0x13, one-cycle grant latency.
    mst_rem[0] = 4; mst_adr[0] = 25'h10;
    cycle();
    check("t1_lat_before", 64'(last_grant), 64'd0);
    cycle();
    check("t1_lat_grant", 64'(last_grant), 64'b0001);
    run_idle("t1_done", 100);
    check("t1_acks", 64'(ack_cnt[0]), 64'd4);
    check("t1_ntenure", 64'(n_ten), 64'd1);
    check("t1_last_adr", 64'(mst_adr[0]), 64'h14);

    // Masters 0, 1, 3 together after reset: order 0, 1, 3 with one idle cycle.
    pulse_reset();
    clear_log();
    mst_rem[0] = 2; mst_adr[0] = 25'h100;
    mst_rem[1] = 2; mst_adr[1] = 25'h200;
    mst_rem[3] = 2; mst_adr[3] = 25'h300;
    run_idle("t2_done", 100);
    check("t2_ntenure", 64'(n_ten), 64'd3);
    check("t2_order0", 64'(ten_idx[0]), 64'd0);
    check("t2_order1", 64'(ten_idx[1]), 64'd1);
    check("t2_order2", 64'(ten_idx[2]), 64'd3);
    check("t2_gap1", 64'(ten_gap[1]), 64'd1);
    check("t2_gap2", 64'(ten_gap[2]), 64'd1);
    check("t2_acks3", 64'(ack_cnt[3]), 64'd2);

    // Pointer now back at 0: masters 1 and 3 together -> 1 first.
    clear_log();
    mst_rem[3] = 1; mst_adr[3] = 25'h380;
    mst_rem[1] = 1; mst_adr[1] = 25'h280;
    run_idle("t2b_done", 50);
    check("t2b_order0", 64'(ten_idx[0]), 64'd1);
    check("t2b_order1", 64'(ten_idx[1]), 64'd3);

    // Master 2 bursts 10 with master 0 waiting: 4, then 0 served, then 6.
    clear_log();
    mst_rem[2] = 10; mst_adr[2] = 25'h400;
    cycle();
    mst_rem[0] = 2; mst_adr[0] = 25'h500;
    run_idle("t3_done", 200);
    check("t3_ntenure", 64'(n_ten), 64'd3);
    check("t3_order0", 64'(ten_idx[0]), 64'd2);
    check("t3_order1", 64'(ten_idx[1]), 64'd0);
    check("t3_order2", 64'(ten_idx[2]), 64'd2);
    check("t3_acks_first", 64'(ten_acks[0]), 64'd4);
    check("t3_acks_m0", 64'(ten_acks[1]), 64'd2);
    check("t3_acks_resume", 64'(ten_acks[2]), 64'd6);
    check("t3_gap1", 64'(ten_gap[1]), 64'd1);
    check("t3_gap2", 64'(ten_gap[2]), 64'd1);

    // Master 1 alone bursts 10: no preemption.
    clear_log();
    mst_rem[1] = 10; mst_adr[1] = 25'h600;
    run_idle("t4_done", 200);
    check("t4_ntenure", 64'(n_ten), 64'd1);
    check("t4_acks", 64'(ack_cnt[1]), 64'd10);

    // Reset asserted in the middle of a master-3 tenure.
    clear_log();
    mst_rem[3] = 10; mst_adr[3] = 25'h700;
    repeat (5) cycle();
    check("t5_pre_grant", 64'(grant_o), 64'b1000);
    @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    check("t5_grant", 64'(grant_o), 64'd0);
    check("t5_scyc",  64'(s_cyc_o), 64'd0);
    check("t5_sstb",  64'(s_stb_o), 64'd0);
    check("t5_sadr",  64'(s_adr_o), 64'd0);
    check("t5_ack",   64'(m_ack_o), 64'd0);
    clear_bus();
    @(negedge clk);
    reset = 1'b1;
    clear_log();
    mst_rem[2] = 2; mst_adr[2] = 25'h780;
    run_idle("t5_done", 50);
    check("t5_first", 64'(ten_idx[0]), 64'd2);
    check("t5_acks", 64'(ack_cnt[2]), 64'd2);

`ifdef SDRAM_ARB_WATCHDOG_EN
    // Slave never acks: error 8 cycles after the strobe, then next master.
    clear_log();
    err_cnt = 0;
    slv_en  = 1'b0;
    mst_rem[1] = 1; mst_adr[1] = 25'h800;
    mst_rem[2] = 1; mst_adr[2] = 25'h900;
    run_idle("t6_done", 100);
    slv_en = 1'b1;
    check("t6_order0", 64'(ten_idx[0]), 64'd1);
    check("t6_order1", 64'(ten_idx[1]), 64'd2);
    check("t6_err_delay", 64'(err_cyc - ten_start[1]), 64'd8);
    check("t6_err_stb", 64'(err_stb), 64'd0);
    check("t6_gap1", 64'(ten_gap[1]), 64'd1);
    check("t6_err_count", 64'(err_cnt), 64'd2);
`else
    check("no_err_seen", 64'(err_cnt), 64'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
